// File: rtl/ifetch_prefetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, buffers returned words with
// their PC+4 in an in-order queue and hands them to decode; redirects flush and restart.
module ifetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc_plus4,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW-1:0] af_rd_q, af_wr_q;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc4   [DEPTH];
    logic [31:0] af_addr [DEPTH];

    logic [CW:0]  credit_sum;
    logic         req_fire, resp_fire, push, pop;
    logic [31:0]  redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign credit_sum      = {1'b0, count_q} + {1'b0, inflight_q};

    // Credits cover both buffered and in-flight words, so a response always has a slot.
    assign mem_req_valid = !reset && !redirect_valid && (credit_sum < (CW + 1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign resp_fire = mem_resp_valid;
    assign push      = resp_fire && (drop_q == '0) && !redirect_valid;

    assign instr_valid    = (count_q != '0);
    assign pop            = instr_valid && instr_ready;
    assign instr          = q_instr[rd_ptr_q];
    assign instr_pc_plus4 = q_pc4[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            count_d    = '0;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_d     = inflight_q - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (resp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            af_rd_q    <= '0;
            af_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            // The address FIFO tracks every outstanding request, dropped or not.
            if (req_fire) begin
                af_wr_q <= af_wr_q + PW'(1);
            end
            if (resp_fire) begin
                af_rd_q <= af_rd_q + PW'(1);
            end
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && req_fire) begin
            af_addr[af_wr_q] <= fetch_pc_q;
        end
        if (!reset && push) begin
            q_instr[wr_ptr_q] <= mem_resp_data;
            q_pc4[wr_ptr_q]   <= af_addr[af_rd_q] + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
            assert (!(resp_fire && (inflight_q == '0)));
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: a latency-configurable memory model feeds the DUT and a
// scoreboard of expected (word, pc+4) pairs is filled on request and drained on each pop.
module tb_ifetch_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready;

    ifetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } pend_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc4;
    } exp_t;

    pend_t       pend[$];
    exp_t        expq[$];
    logic [31:0] exp_addr;
    int          cyc;
    int          lat_min, lat_max;
    bit          mem_rdy_rand;

    int          n_tests, n_fail;
    int          n_fire, n_pop;
    int          first_fire_cyc, first_valid_cyc;
    bit          have_pop;
    logic [31:0] first_pop_pc4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic do_cycle(input bit rst, input bit rdy, input bit redir,
                            input logic [31:0] rpc);
        int   live;
        int   dcount;
        int   due;
        bit   fire, rf, pop;
        exp_t e;
        @(negedge clk);
        reset          = rst;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = mem_rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend[0].addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
        end
        #1;
        live = 0;
        foreach (pend[i]) if (pend[i].live) live++;
        dcount = expq.size() - live;
        check_eq("req_valid", 32'(mem_req_valid),
                 32'(!rst && !redir && (dcount + pend.size() < DEPTH)));
        check_eq("instr_valid", 32'(instr_valid), 32'(dcount != 0));
        if (mem_req_valid === 1'b1) check_eq("req_addr", mem_req_addr, exp_addr);
        fire = (mem_req_valid === 1'b1) && mem_req_ready;
        rf   = mem_resp_valid;
        pop  = (instr_valid === 1'b1) && rdy;
        if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (fire) begin
            n_fire++;
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end
        if (pop && expq.size() > 0) begin
            e = expq.pop_front();
            check_eq("pop_instr", instr, e.word);
            check_eq("pop_pc4", instr_pc_plus4, e.pc4);
            n_pop++;
            if (!have_pop) begin
                have_pop      = 1'b1;
                first_pop_pc4 = instr_pc_plus4;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
            expq.delete();
            exp_addr = RESET_PC;
        end else begin
            if (rf) void'(pend.pop_front());
            if (redir) begin
                foreach (pend[i]) pend[i].live = 1'b0;
                expq.delete();
                exp_addr = {rpc[31:2], 2'b00};
            end
            if (fire) begin
                due = cyc - 1 + $urandom_range(lat_max, lat_min);
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                pend.push_back('{addr: exp_addr, due: due, live: 1'b1});
                expq.push_back('{word: mem_word(exp_addr), pc4: exp_addr + 32'd4});
                exp_addr = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic run_until_pop(input string tag, input int max_cycles);
        have_pop = 1'b0;
        for (int i = 0; i < max_cycles && !have_pop; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        if (!have_pop) check_eq({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        lat_min = 1; lat_max = 1; mem_rdy_rand = 1'b0;
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        exp_addr = RESET_PC;
        repeat (2) @(posedge clk);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Startup latency and sustained throughput with a 1-cycle memory.
        first_fire_cyc = -1; first_valid_cyc = -1;
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("startup_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
        n_pop = 0;
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("throughput", 32'(n_pop), 32'd8);

        // Decode stalled: credits stop fetch after DEPTH requests.
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        n_fire = 0;
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("stall_fires", 32'(n_fire), 32'(DEPTH));
        run_until_pop("stall_release", 4);
        check_eq("stall_first_pc4", first_pop_pc4, 32'h4);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // 3-cycle memory, redirect with two requests in flight.
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("inflight_before_redirect", 32'(n_pop >= 0 && pend.size() == 2), 32'd1);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        run_until_pop("redir_drop", 20);
        check_eq("redir_first_pc4", first_pop_pc4, 32'h104);

        // Redirect while a response arrives and a pop completes.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        n_pop = 0;
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check_eq("redir_pop_done", 32'(n_pop), 32'd1);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("redir_empty", 32'(instr_valid), 32'd0);
        run_until_pop("redir_resume", 20);
        check_eq("redir_resume_pc4", first_pop_pc4, 32'h204);

        // Address wrap at the top of the space.
        lat_min = 1; lat_max = 1;
        do_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        run_until_pop("wrap", 20);
        check_eq("wrap_pc4", first_pop_pc4, 32'h0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Reset with a full queue.
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("full_before_reset", 32'(instr_valid), 32'd1);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_until_pop("after_reset", 10);
        check_eq("after_reset_pc4", first_pop_pc4, RESET_PC + 32'd4);

        // Random traffic: variable latency, memory stalls, decode stalls, redirects.
        lat_min = 1; lat_max = 3; mem_rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'b0, 1'($urandom_range(1, 0)), ($urandom_range(29, 0) == 0),
                     $urandom());
        end
        mem_rdy_rand = 1'b0;
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("drain_empty", 32'(expq.size()), 32'(pend.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
